// File: rtl/undo_log_writer.sv
// undo_log_writer: logs the old L2 word for each speculative store before performing it; UNDO_LOG_DEDUP_EN skips re-logging repeated addresses
module undo_log_writer #(
  parameter int ID_BASE     = 0,
  parameter int LOG_ENTRIES = 4,
  parameter int SLOT_W      = 7,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   task_start_valid,
  input  logic [SLOT_W-1:0]      task_start_slot,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   finish_valid,
  output logic                   finish_ready,
  output logic                   finish_task_valid,
  output logic [SLOT_W-1:0]      finish_task_slot,
  output logic                   finish_task_undo_log_write,
  output logic                   undo_log_valid,
  input  logic                   undo_log_ready,
  output logic [LOG_ENTRIES-1:0] undo_log_id,
  output logic [ADDR_W-1:0]      undo_log_addr,
  output logic [DATA_W-1:0]      undo_log_data,
  output logic [SLOT_W-1:0]      undo_log_slot,
  output logic                   overflow,
  output logic                   l2_arvalid,
  input  logic                   l2_arready,
  output logic [ADDR_W-1:0]      l2_araddr,
  output logic [15:0]            l2_arid,
  input  logic                   l2_rvalid,
  output logic                   l2_rready,
  input  logic [DATA_W-1:0]      l2_rdata,
  output logic                   l2_awvalid,
  input  logic                   l2_awready,
  output logic [ADDR_W-1:0]      l2_awaddr,
  output logic [15:0]            l2_awid,
  output logic                   l2_wvalid,
  input  logic                   l2_wready,
  output logic [DATA_W-1:0]      l2_wdata,
  output logic [3:0]             l2_wstrb,
  output logic                   l2_wlast,
  input  logic                   l2_bvalid,
  output logic                   l2_bready
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, LOG, WR, WB} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, old_q, old_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [LOG_ENTRIES-1:0] cnt_q, cnt_d;
  logic wrote_q, wrote_d, ovf_q, ovf_d, wr_ready_q, wr_ready_d, fin_q, fin_d;
  logic accept, hit;
`ifdef UNDO_LOG_DEDUP_EN
  logic [3:0][ADDR_W-1:0] tag_q, tag_d;
  logic [3:0] tv_q, tv_d;
  logic [1:0] rr_q, rr_d;
  // address match against previously logged words of this task
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 4; i++) hit = hit | (tv_q[i] & (tag_q[i] == wr_addr));
  end
`else
  assign hit = 1'b0;
`endif
  // wr_ready_q guards against re-accepting the store the core still holds during its completion pulse
  assign accept = (state_q == IDLE) & wr_valid & ~ovf_q & ~wr_ready_q;
  assign finish_ready = (state_q == IDLE) & finish_valid & ~wr_ready_q & (~wr_valid | ovf_q);
  assign wr_ready = wr_ready_q;
  assign finish_task_valid = fin_q;
  assign finish_task_slot = slot_q;
  assign finish_task_undo_log_write = wrote_q;
  assign undo_log_valid = state_q == LOG;
  assign undo_log_id = cnt_q;
  assign undo_log_addr = addr_q;
  assign undo_log_data = old_q;
  assign undo_log_slot = slot_q;
  assign overflow = ovf_q;
  assign l2_arvalid = state_q == RD_A;
  assign l2_araddr = addr_q;
  assign l2_arid = 16'(ID_BASE);
  assign l2_rready = state_q == RD_D;
  assign l2_awvalid = state_q == WR;
  assign l2_wvalid = state_q == WR;
  assign l2_awaddr = addr_q;
  assign l2_awid = 16'(ID_BASE);
  assign l2_wdata = data_q;
  assign l2_wstrb = 4'hF;
  assign l2_wlast = 1'b1;
  assign l2_bready = state_q == WB;
  // next-state and task bookkeeping
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    old_d = old_q;
    slot_d = slot_q;
    cnt_d = cnt_q;
    wrote_d = wrote_q;
    ovf_d = ovf_q;
    wr_ready_d = 1'b0;
    fin_d = finish_ready;
`ifdef UNDO_LOG_DEDUP_EN
    tag_d = tag_q;
    tv_d = tv_q;
    rr_d = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (task_start_valid) begin
          slot_d = task_start_slot;
          cnt_d = '0;
          wrote_d = 1'b0;
          ovf_d = 1'b0;
`ifdef UNDO_LOG_DEDUP_EN
          tv_d = '0;
          rr_d = '0;
`endif
        end
        if (accept) begin
          addr_d = wr_addr;
          data_d = wr_data;
          state_d = hit ? WR : RD_A;
        end
      end
      RD_A: state_d = l2_arready ? RD_D : RD_A;
      RD_D: begin
        old_d = l2_rvalid ? l2_rdata : old_q;
        state_d = l2_rvalid ? LOG : RD_D;
      end
      LOG: if (undo_log_ready) begin
        wrote_d = 1'b1;
        ovf_d = ovf_q | (&cnt_q);
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`ifdef UNDO_LOG_DEDUP_EN
        tag_d[rr_q] = addr_q;
        tv_d[rr_q] = 1'b1;
        rr_d = rr_q + 1'b1;
`endif
        state_d = WR;
      end
      WR: state_d = (l2_awready & l2_wready) ? WB : WR;
      WB: begin
        wr_ready_d = l2_bvalid;
        state_d = l2_bvalid ? IDLE : WB;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wrote_q <= 1'b0;
      ovf_q <= 1'b0;
      wr_ready_q <= 1'b0;
      fin_q <= 1'b0;
`ifdef UNDO_LOG_DEDUP_EN
      tv_q <= '0;
      rr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wrote_q <= wrote_d;
      ovf_q <= ovf_d;
      wr_ready_q <= wr_ready_d;
      fin_q <= fin_d;
`ifdef UNDO_LOG_DEDUP_EN
      tv_q <= tv_d;
      rr_q <= rr_d;
`endif
    end
  end
  // datapath registers need no reset
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    old_q <= old_d;
    slot_q <= slot_d;
`ifdef UNDO_LOG_DEDUP_EN
    tag_q <= tag_d;
`endif
  end
endmodule

// File: tb/tb_undo_log_writer.sv
// tb_undo_log_writer: scoreboard bench for undo_log_writer
module tb_undo_log_writer;
  logic clk = 0, rst = 1;
  logic task_start_valid = 0, wr_valid = 0, finish_valid = 0, log_rdy = 1;
  logic [6:0] task_start_slot = 0;
  logic [31:0] wr_addr = 0, wr_data = 0, rd_data = 0;
  logic b_en = 1, b_force = 0;
  logic wr_ready, finish_ready, finish_task_valid, finish_task_undo_log_write, undo_log_valid, overflow;
  logic [6:0] finish_task_slot, undo_log_slot;
  logic [3:0] undo_log_id, l2_wstrb;
  logic [31:0] undo_log_addr, undo_log_data, l2_araddr, l2_awaddr, l2_wdata;
  logic [15:0] l2_arid, l2_awid;
  logic l2_arvalid, l2_rready, l2_rvalid, l2_awvalid, l2_wvalid, l2_wlast, l2_bready, l2_bvalid;
  int checks = 0, failures = 0, log_seen = 0, ar_seen = 0, logs_total = 0;
  logic [3:0] cnt_m = 0;
  logic [6:0] slot_m = 0;
  logic ovf_m = 0;
  logic [74:0] exp_log[$];
  logic [95:0] exp_wr[$];
  logic [7:0] exp_fin[$];
  assign l2_rvalid = l2_rready;
  assign l2_bvalid = b_force | (b_en & l2_bready);
  always #5 clk = ~clk;
  undo_log_writer dut (
    .clk(clk), .rst(rst), .task_start_valid(task_start_valid), .task_start_slot(task_start_slot),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .finish_valid(finish_valid), .finish_ready(finish_ready), .finish_task_valid(finish_task_valid),
    .finish_task_slot(finish_task_slot), .finish_task_undo_log_write(finish_task_undo_log_write),
    .undo_log_valid(undo_log_valid), .undo_log_ready(log_rdy), .undo_log_id(undo_log_id),
    .undo_log_addr(undo_log_addr), .undo_log_data(undo_log_data), .undo_log_slot(undo_log_slot),
    .overflow(overflow), .l2_arvalid(l2_arvalid), .l2_arready(1'b1), .l2_araddr(l2_araddr), .l2_arid(l2_arid),
    .l2_rvalid(l2_rvalid), .l2_rready(l2_rready), .l2_rdata(rd_data),
    .l2_awvalid(l2_awvalid), .l2_awready(1'b1), .l2_awaddr(l2_awaddr), .l2_awid(l2_awid),
    .l2_wvalid(l2_wvalid), .l2_wready(1'b1), .l2_wdata(l2_wdata), .l2_wstrb(l2_wstrb), .l2_wlast(l2_wlast),
    .l2_bvalid(l2_bvalid), .l2_bready(l2_bready)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // monitor: compares every DUT handshake against the queued expectation
  always @(negedge clk) if (!rst) begin
    if (l2_arvalid) ar_seen++;
    if (undo_log_valid && log_rdy) begin
      log_seen++;
      if (exp_log.size() == 0) chk("log_unexpected", 1, 0);
      else chk("log_record", {undo_log_id, undo_log_addr, undo_log_data, undo_log_slot}, exp_log.pop_front());
    end
    if (l2_awvalid && l2_wvalid) begin
      chk("write_fixed", {l2_wstrb, l2_wlast, l2_awid, l2_arid}, {4'hF, 1'b1, 32'h0});
      if (exp_wr.size() == 0) chk("write_unexpected", 1, 0);
      else chk("write_order_addr_data", {log_seen, l2_awaddr, l2_wdata}, exp_wr.pop_front());
    end
    if (finish_task_valid) begin
      if (exp_fin.size() == 0) chk("finish_unexpected", 1, 0);
      else chk("finish_task", {finish_task_slot, finish_task_undo_log_write}, exp_fin.pop_front());
    end
  end
  task automatic do_start(input logic [6:0] s);
    task_start_valid = 1;
    task_start_slot = s;
    tick;
    task_start_valid = 0;
    slot_m = s;
    cnt_m = 0;
    ovf_m = 0;
  endtask
  task automatic expect_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] o, input bit logged);
    rd_data = o;
    if (logged) begin
      exp_log.push_back({cnt_m, a, o, slot_m});
      if (cnt_m == 4'hF) ovf_m = 1;
      else cnt_m++;
      logs_total++;
    end
    exp_wr.push_back({logs_total, a, d});
    wr_addr = a;
    wr_data = d;
  endtask
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] o, input bit logged, input int lat, input int hold);
    int n;
    logic [74:0] snap;
    expect_store(a, d, o, logged);
    log_rdy = (hold == 0);
    wr_valid = 1;
    if (hold > 0) begin
      n = 0;
      while (!undo_log_valid && n < 20) begin tick; n++; end
      chk("log_reach", undo_log_valid, 1);
      snap = {undo_log_id, undo_log_addr, undo_log_data, undo_log_slot};
      for (int k = 0; k < hold; k++) begin
        tick;
        chk("log_hold", {undo_log_valid, l2_awvalid, l2_wvalid, undo_log_id, undo_log_addr, undo_log_data, undo_log_slot}, {3'b100, snap});
      end
      log_rdy = 1;
    end
    n = 0;
    while (!wr_ready && n < 50) begin tick; n++; end
    wr_valid = 0;
    chk("wr_ready_seen", wr_ready, 1);
    if (lat > 0) chk("latency", n, lat);
    tick;
    chk("wr_ready_pulse", wr_ready, 0);
  endtask
  task automatic do_finish(input bit w);
    finish_valid = 1;
    #1;
    chk("finish_ready", finish_ready, 1);
    exp_fin.push_back({slot_m, w});
    @(posedge clk);
    #1;
    finish_valid = 0;
    tick;
    tick;
  endtask
  function automatic logic [9:0] outs();
    return {wr_ready, finish_ready, finish_task_valid, undo_log_valid, overflow, l2_arvalid, l2_rready, l2_awvalid, l2_wvalid, l2_bready};
  endfunction
  initial begin
    int n, ar0;
    tick;
    tick;
    chk("reset_outputs", outs(), 0);
    rst = 0;
    do_start(5);
    do_store(32'h100, 32'hAA, 32'h11, 1, 6, 0);
    do_start(5);
    do_store(32'h200, 32'h1, 32'h21, 1, 6, 0);
    do_store(32'h204, 32'h2, 32'h22, 1, 6, 0);
    do_store(32'h208, 32'h3, 32'h23, 1, 6, 0);
    do_finish(1);
    do_start(6);
    ar0 = ar_seen;
    do_finish(0);
    chk("no_l2_traffic", ar_seen, ar0);
    do_start(2);
    do_store(32'h300, 32'hBEEF, 32'hCAFE, 1, 0, 10);
    do_start(9);
    for (int i = 0; i < 16; i++) do_store(32'h1000 + 4 * i, i, 32'hF00 + i, 1, 6, 0);
    chk("overflow_set", overflow, ovf_m);
    wr_addr = 32'h900;
    wr_valid = 1;
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("overflow_stall", {wr_ready, l2_arvalid, undo_log_valid}, 0);
    end
    wr_valid = 0;
    do_start(9);
    chk("overflow_clear", overflow, 0);
    do_store(32'h904, 32'h44, 32'h55, 1, 6, 0);
`ifdef UNDO_LOG_DEDUP_EN
    do_start(3);
    do_store(32'h40, 32'h1, 32'h77, 1, 6, 0);
    do_store(32'h40, 32'h2, 32'h0, 0, 3, 0);
`endif
    do_start(4);
    expect_store(32'h500, 32'h66, 32'h99, 1);
    b_en = 0;
    wr_valid = 1;
    n = 0;
    while (!l2_bready && n < 50) begin tick; n++; end
    chk("wb_reach", l2_bready, 1);
    wr_valid = 0;
    rst = 1;
    tick;
    chk("reset_mid_store", outs(), 0);
    rst = 0;
    b_en = 1;
    b_force = 1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("late_bvalid", {wr_ready, l2_arvalid, undo_log_valid}, 0);
    end
    b_force = 0;
    do_start(1);
    do_store(32'h600, 32'h7, 32'h8, 1, 6, 0);
    do_finish(1);
    chk("queues_drained", {exp_log.size(), exp_wr.size(), exp_fin.size()}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/undo_log_writer.md
Name: undo_log_writer

Overview:
- Per-core write-interception stage that sits directly upstream of the tile undo log.
- For every speculative store from a core, it:
  - reads the old word from L2,
  - emits one undo record (id, addr, old data, cq slot) to the undo log,
  - then performs the store and returns completion to the core.
- Tracks the per-task record count and reports at task finish whether any record was written.

Parameters:
- ID_BASE, 0, AXI id driven on ar/aw; B and R ids are ignored.
- LOG_ENTRIES, 4, log2 of undo records per task; the id counter width is LOG_ENTRIES.
- SLOT_W, 7, cq slice slot width.
- ADDR_W, 32, word address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- task_start_valid  in  1  core begins a task; slot is latched.
- task_start_slot  in  SLOT_W  cq slot of the new task.
- wr_valid  in  1  core store request.
- wr_ready  out  1  one-cycle pulse when the store is fully retired (B received).
- wr_addr  in  ADDR_W  store address.
- wr_data  in  DATA_W  store data.
- finish_valid  in  1  core finishes the task.
- finish_ready  out  1  finish accepted; high only in IDLE.
- finish_task_valid  out  1  registered finish pulse to the undo log.
- finish_task_slot  out  SLOT_W  slot of the finished task.
- finish_task_undo_log_write  out  1  task logged at least one record.
- undo_log_valid  out  1  undo record valid.
- undo_log_ready  in  1  undo log accepts the record.
- undo_log_id  out  LOG_ENTRIES  record index within the task.
- undo_log_addr  out  ADDR_W  logged address.
- undo_log_data  out  DATA_W  old data.
- undo_log_slot  out  SLOT_W  task slot.
- overflow  out  1  per-task record capacity exhausted.
- l2_arvalid / l2_arready / l2_araddr / l2_arid  out/in/out(ADDR_W)/out(16)  L2 read address.
- l2_rvalid / l2_rready / l2_rdata  in/out/in(DATA_W)  L2 read data.
- l2_awvalid / l2_awready / l2_awaddr / l2_awid  out/in/out(ADDR_W)/out(16)  L2 write address.
- l2_wvalid / l2_wready / l2_wdata / l2_wstrb / l2_wlast  out/in/out/out(4)/out  L2 write data.
- l2_bvalid / l2_bready  in/out  L2 write response.

Behaviour:
- Reset (synchronous, rst=1):
  - state=IDLE, cnt=0, wrote=0, overflow=0.
  - All valid/ready outputs are 0; finish_task_valid=0.
  - Any reset mid-transaction drops it; L2 responses arriving after reset are ignored.
- Fixed L2 fields: awsize=2 (word), awlen=0, l2_wstrb=4'hF, l2_wlast=1, l2_arid=l2_awid=ID_BASE.
- task_start_valid: in IDLE only, latch slot and clear cnt, wrote and overflow. In any other state it is ignored; the core does not start a task mid-store.
- Store FSM (one store in flight):
  - IDLE:
    - wr_valid & !overflow: latch addr/data, go to RD_A.
    - wr_valid & overflow: stay in IDLE; the store stalls (wr_ready stays 0).
  - RD_A: l2_arvalid=1, araddr=latched addr. On arready go to RD_D.
  - RD_D: l2_rready=1. On rvalid, capture rdata as old, go to LOG.
  - LOG: undo_log_valid=1, id=cnt, addr=latched addr, data=old, slot=latched slot. On undo_log_ready:
    - cnt++ and wrote=1.
    - If cnt was 2**LOG_ENTRIES-1, set overflow=1; cnt saturates and does not wrap.
    - Go to WR.
  - WR: l2_awvalid=l2_wvalid=1. Advance only when awready & wready are high in the same cycle, then go to WB.
  - WB: l2_bready=1. On bvalid, pulse wr_ready for one cycle and go to IDLE.
- Ordering: the undo record is always handshaken before the aw/w for the same store is presented. The undo log therefore never observes a write whose old value is unlogged.
- Latency: minimum 6 cycles from wr_valid to wr_ready with zero-wait L2 and log.
- Finish:
  - In IDLE with finish_valid and no wr_valid: finish_ready=1. Next cycle finish_task_valid=1 for exactly one cycle, with the latched slot and undo_log_write=wrote.
  - If finish_valid and wr_valid are both high in IDLE, the store is served first.
- Records per task are capped at 2**LOG_ENTRIES. Once overflow=1, further stores of that task stall until task_start_valid, or until the task is aborted externally.

Optional Feature:
- Macro: UNDO_LOG_DEDUP_EN.
- Defined:
  - Adds a 4-entry address register set, cleared on task_start.
  - A store whose address matches a valid entry skips RD_A/RD_D/LOG and goes IDLE->WR directly; cnt is unchanged. The first value logged is the one restored.
  - A non-matching logged address is inserted round-robin.
- Undefined: every store is logged.

Test Plan:
- Start slot 5; store addr 0x100 data 0xAA (old 0x11) -> one undo record id=0 addr=0x100 data=0x11 slot=5; then aw 0x100 w 0xAA; wr_ready pulse at cycle 6.
- Three stores, then finish -> ids 0,1,2; finish_task_valid with slot 5 and undo_log_write=1.
- Start, then immediately finish -> finish_task_undo_log_write=0; no L2 traffic.
- undo_log_ready held 0 for 10 cycles -> undo_log_valid and fields stable; no aw/w issued until acceptance.
- LOG_ENTRIES=2 with 5 stores -> 4 records; overflow=1; 5th store stalls; task_start clears it.
- rst asserted in WB -> all outputs 0 next cycle; a late bvalid causes no wr_ready.
- DEDUP: stores to 0x40, 0x40 -> single record; second store goes directly to WR.
